t_bird_seq: RTL
===============

Name: t_bird_seq

Overview:
Parametrised tail-light sequencer; next generation of the team's fixed 4+4 lamp Thunderbird block.
- Drives LAMPS lamps per side with inner-to-outer fill sequencing.
- Step rate is set by a built-in prescaler.
- Supports left, right, hazard and brake combinations, and restarts cleanly on mode change.
- Sits between the switch/debounce logic and the lamp driver outputs.

Parameters:
LAMPS, 4, lamps per side (>=2)
TICK_DIV, 1, clock cycles per sequence step (>=1; 1 = step every cycle)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
mode  input  3  bit0 left, bit1 right, bit2 brake
lamps_left  output  LAMPS  left lamps, bit0 innermost
lamps_right  output  LAMPS  right lamps, bit0 innermost
phase  output  $clog2(LAMPS+1)  current fill count
step  output  1  one-cycle pulse on each sequence advance

Behaviour:
Interface and reset:
- One clock domain.
- Reset is asynchronous and active-low; reset_n=0 immediately clears all state, with no clock needed.
- Reset values: mode_q=000, presc=0, fill=0, lamps_left=0, lamps_right=0, phase=0, step=0.

Registered state:
- mode_q (3 bits).
- presc, 0..TICK_DIV-1, width max(1,$clog2(TICK_DIV)).
- fill, 0..LAMPS.
- flash bit (optional feature only).
- Outputs decode from registered state only; there is no combinational path from mode to any output.

Mode-change detection, each rising edge:
- If mode != mode_q: mode_q<=mode, presc<=0, fill<=0, step<=0. This overrides any step due in the same cycle.
- The new mode is therefore visible on the outputs from the same edge, starting at fill=0.

Prescaler (mode unchanged):
- If presc==TICK_DIV-1: presc<=0 and step<=1.
- Otherwise presc<=presc+1 and step<=0.
- step is registered, so it is high during the cycle in which the new fill is visible.

Fill counter:
- On a step, fill<=(fill==LAMPS)?0:fill+1.
- Sequence period is LAMPS+1 steps.
- fill runs in every mode but only affects sequencing sides.

Sequencing side pattern:
- bit i lit iff i < fill (thermometer).

Decode by mode_q:
- 000: both sides off.
- 001 left: left sequences, right off.
- 010 right: right sequences, left off.
- 011 hazard: both sides sequence in lockstep (identical vectors).
- 100 brake: both sides all-on.
- 101 brake+left: left sequences, right all-on.
- 110 brake+right: right sequences, left all-on.
- 111: treated as hazard; brake is ignored.

phase mirrors fill.

Optional Feature:
Macro: TBIRD_BRAKE_FLASH_EN
- Defined:
  - In mode_q=100, both sides alternate all-on / all-off, toggling on each step.
  - A flash register is cleared on mode change and on reset, so the first step window after entering 100 is all-on.
  - Modes 101 and 110 are unaffected; their brake side stays steady.
- Undefined: mode 100 is steady all-on, and the flash register is not present.

Decomposition:
- Package t_bird_pkg:
  - mode bit-index constants (MODE_LEFT=0, MODE_RIGHT=1, MODE_BRAKE=2);
  - named 3-bit mode constants (OFF, LEFT, RIGHT, HAZARD, BRAKE, BRAKE_LEFT, BRAKE_RIGHT, HAZARD_BRAKE);
  - a thermometer-decode function therm(fill) returning LAMPS bits.
- Sub-module tick_prescaler:
  - parameter TICK_DIV; inputs clock, reset_n, clr; output step.
  - The parent drives clr from mode-change detection.

Test Plan:
- LAMPS=4, TICK_DIV=1. Reset, then mode=001 -> lamps_left per cycle 0000, 0001, 0011, 0111, 1111, 0000, ...; lamps_right=0000 throughout; step high every cycle after the first.
- LAMPS=4, TICK_DIV=3, mode=011 -> lamps_left==lamps_right at every cycle; fill advances every 3rd cycle; period is 15 cycles.
- LAMPS=4, mode=101 -> lamps_right=1111 constant while lamps_left sequences. Then switch to 110 at fill=3 -> on that edge lamps_left=1111, lamps_right=0000, phase=0, step=0.
- LAMPS=6, TICK_DIV=2, mode=010 -> lamps_right reaches 111111 and wraps to 000000 after 7 steps (14 cycles). Assert reset_n=0 mid-cycle at fill=4 -> all outputs 0 immediately without a clock edge. After release, the sequence restarts from 0.
- mode=111 -> identical to 011. Mode=100 -> both sides 1111 steady. With TBIRD_BRAKE_FLASH_EN and TICK_DIV=2, mode=100 -> both sides 1111 for 2 cycles, 0000 for 2 cycles, repeating.
- Mode toggled 001->000->001 on consecutive cycles -> fill and presc restart each time; no step pulse is emitted on a change cycle.

Source files
------------

// File: rtl/t_bird_pkg.sv
// Shared mode encodings and the thermometer decode for the tail-light sequencer.
// Combinational helpers only: no latency, no flow control.
package t_bird_pkg;

  localparam int MODE_LEFT  = 0;
  localparam int MODE_RIGHT = 1;
  localparam int MODE_BRAKE = 2;

  localparam logic [2:0] OFF          = 3'b000;
  localparam logic [2:0] LEFT         = 3'b001;
  localparam logic [2:0] RIGHT        = 3'b010;
  localparam logic [2:0] HAZARD       = 3'b011;
  localparam logic [2:0] BRAKE        = 3'b100;
  localparam logic [2:0] BRAKE_LEFT   = 3'b101;
  localparam logic [2:0] BRAKE_RIGHT  = 3'b110;
  localparam logic [2:0] HAZARD_BRAKE = 3'b111;

  // Callers truncate to their lamp count, so LAMPS is limited to THERM_W.
  localparam int THERM_W = 32;

  function automatic logic [THERM_W-1:0] therm(input int fill);
    logic [THERM_W-1:0] v;
    v = '0;
    for (int i = 0; i < THERM_W; i++) v[i] = (i < fill);
    return v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into sequence steps; clr restarts the count and suppresses that cycle's step.
// tick is the same-edge advance strobe, step its registered one-cycle copy; no backpressure.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  output logic tick,
  output logic step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          step_q;

  assign tick = ~clr & (presc_q == LAST);
  assign step = step_q;

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (clr || presc_q == LAST) presc_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      step_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      step_q  <= tick;
    end
  end

endmodule

// File: rtl/t_bird_seq.sv
// Tail-light sequencer: inner-to-outer fill per side, outputs decoded from registered state only.
// New mode visible one edge after it is applied, restarting at fill 0; no backpressure. Option: TBIRD_BRAKE_FLASH_EN.
module t_bird_seq
  import t_bird_pkg::*;
#(
  parameter int LAMPS    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2:0]                 mode,
  output logic [LAMPS-1:0]           lamps_left,
  output logic [LAMPS-1:0]           lamps_right,
  output logic [$clog2(LAMPS+1)-1:0] phase,
  output logic                       step
);

  localparam int FW = $clog2(LAMPS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LAMPS);

  logic [2:0]       mode_q;
  logic [FW-1:0]    fill_q, fill_d;
  logic             mode_chg;
  logic             tick;
  logic             brake_on;
  logic [LAMPS-1:0] seq;

  assign mode_chg = (mode != mode_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (mode_chg),
    .tick    (tick),
    .step    (step)
  );

  always_comb begin
    fill_d = fill_q;
    if (mode_chg)  fill_d = '0;
    else if (tick) fill_d = (fill_q == FILL_MAX) ? '0 : fill_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= OFF;
      fill_q <= '0;
    end else begin
      mode_q <= mode;
      fill_q <= fill_d;
    end
  end

`ifdef TBIRD_BRAKE_FLASH_EN
  logic flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (mode_chg)  flash_d = 1'b0;
    else if (tick) flash_d = ~flash_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) flash_q <= 1'b0;
    else          flash_q <= flash_d;
  end

  assign brake_on = ~flash_q;
`else
  assign brake_on = 1'b1;
`endif

  assign seq   = LAMPS'(therm(int'(fill_q)));
  assign phase = fill_q;

  // Brake on 111 is deliberately dropped so it reads exactly like hazard.
  always_comb begin
    lamps_left  = '0;
    lamps_right = '0;
    case (mode_q)
      LEFT:  lamps_left  = seq;
      RIGHT: lamps_right = seq;
      HAZARD, HAZARD_BRAKE: begin
        lamps_left  = seq;
        lamps_right = seq;
      end
      BRAKE: begin
        lamps_left  = {LAMPS{brake_on}};
        lamps_right = {LAMPS{brake_on}};
      end
      BRAKE_LEFT: begin
        lamps_left  = seq;
        lamps_right = '1;
      end
      BRAKE_RIGHT: begin
        lamps_left  = '1;
        lamps_right = seq;
      end
      default: ;
    endcase
  end

endmodule
